// File: rtl/seven_segment_scanner_if.sv
// Load handshake between the processor output register and the scanner.
// The master drives the display word and load; the slave answers with ack.
interface seven_segment_scanner_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic                  ack;

  modport master (
    output load,
    output value,
    input  ack
  );

  modport slave (
    input  load,
    input  value,
    output ack
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed seven-segment scan controller sharing one decoder
// across DIGITS digits, with leading-zero blanking and a load/ack port.
module seven_segment_scanner #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  seven_segment_scanner_if.slave bus,
  input  logic                blank_lz,
  output logic [3:0]          nibble,
  output logic [DIGITS-1:0]   digit_an_n
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] disp;
  logic                tick;
  logic [DIGITS-1:0]   blank;
  logic                lead;

  assign tick = (cnt == CW'(DIV - 1));

  // A digit is blank while it and every digit above it are zero.
  always_comb begin
    blank = '0;
    lead  = blank_lz;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lead     = lead && (disp[4*i +: 4] == 4'h0);
      blank[i] = lead;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      disp       <= '0;
      bus.ack    <= 1'b0;
      nibble     <= 4'h0;
      digit_an_n <= '1;
    end else begin
      cnt     <= tick ? '0 : cnt + 1'b1;
      bus.ack <= bus.load;
      if (tick) begin
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end
      if (bus.load) begin
        disp <= bus.value;
      end
      nibble <= disp[{idx, 2'b00} +: 4];
      if (blank[idx]) begin
        digit_an_n <= '1;
      end else begin
        digit_an_n <= ~(DIGITS'(1) << idx);
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench: two scanners (DIV=4 and DIV=1) against a
// time-indexed reference model of the scan, blanking and load/ack.
module tb_seven_segment_scanner;

  logic        clk;
  logic        rst_n;
  logic        blank_lz;
  logic [3:0]  nib4, nib1;
  logic [3:0]  an4, an1;

  seven_segment_scanner_if #(.DIGITS(4)) bus4 ();
  seven_segment_scanner_if #(.DIGITS(4)) bus1 ();

  assign bus1.load  = bus4.load;
  assign bus1.value = bus4.value;

  seven_segment_scanner #(.DIGITS(4), .DIV(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus4.slave),
    .blank_lz   (blank_lz),
    .nibble     (nib4),
    .digit_an_n (an4)
  );

  seven_segment_scanner #(.DIGITS(4), .DIV(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus1.slave),
    .blank_lz   (blank_lz),
    .nibble     (nib1),
    .digit_an_n (an1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] nib;
    logic [3:0] an;
    logic       ack;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int total = 0;
  int bad   = 0;

  int unsigned n[2];
  logic [15:0] mdisp[2];

  function automatic exp_t reset_exp();
    exp_t e;
    e.nib = 4'h0;
    e.an  = 4'hF;
    e.ack = 1'b0;
    return e;
  endfunction

  // Output after an edge: digit slot from elapsed time, data from disp.
  function automatic exp_t model(int unsigned t, int div,
                                 logic [15:0] d, logic blz, logic ld);
    exp_t e;
    int   dig;
    logic [15:0] upper;
    dig   = int'((t / div) % 4);
    upper = d >> (4 * dig);
    e.nib = upper[3:0];
    e.ack = ld;
    if (blz && dig >= 1 && upper == 16'h0) e.an = 4'hF;
    else e.an = ~(4'b0001 << dig);
    return e;
  endfunction

  initial begin
    n[0] = 0; n[1] = 0;
    mdisp[0] = '0; mdisp[1] = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q0.delete();
        q1.delete();
        n[0] = 0; n[1] = 0;
        mdisp[0] = '0; mdisp[1] = '0;
        q0.push_back(reset_exp());
        q1.push_back(reset_exp());
      end else begin
        q0.push_back(model(n[0], 4, mdisp[0], blank_lz, bus4.load));
        q1.push_back(model(n[1], 1, mdisp[1], blank_lz, bus4.load));
        for (int j = 0; j < 2; j++) begin
          if (bus4.load) mdisp[j] = bus4.value;
          n[j]++;
        end
      end
    end
  end

  task automatic check(string name, logic [3:0] got, logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("div4_nibble", nib4, e.nib);
        check("div4_an", an4, e.an);
        check("div4_ack", {3'b0, bus4.ack}, {3'b0, e.ack});
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("div1_nibble", nib1, e.nib);
        check("div1_an", an1, e.an);
        check("div1_ack", {3'b0, bus1.ack}, {3'b0, e.ack});
      end
    end
  end

  task automatic step(int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(logic [15:0] v);
    bus4.load  = 1'b1;
    bus4.value = v;
    step();
    bus4.load  = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    int          waited;
    rst_n      = 1'b0;
    blank_lz   = 1'b0;
    bus4.load  = 1'b0;
    bus4.value = '0;
    step(4);
    bus4.load = 1'b1;
    rst_n     = 1'b1;
    step();
    bus4.load = 1'b0;
    step(8);

    do_load(16'h1234);
    step(36);

    do_load(16'hBEEF);
    step(3);
    bus4.load = 1'b1;
    bus4.value = 16'h1111;
    step();
    bus4.value = 16'h2222;
    step();
    bus4.value = 16'h3333;
    step();
    bus4.load = 1'b0;
    step(20);

    blank_lz = 1'b1;
    do_load(16'h0050);
    step(20);
    do_load(16'h0000);
    step(20);
    blank_lz = 1'b0;
    step(20);

    repeat (400) begin
      v = 16'($urandom);
      case ($urandom_range(3))
        0: v &= 16'h0FFF;
        1: v &= 16'h00FF;
        2: v &= 16'h000F;
        default: ;
      endcase
      bus4.value = v;
      bus4.load  = ($urandom_range(3) == 0);
      if ($urandom_range(15) == 0) blank_lz = ~blank_lz;
      step();
    end
    bus4.load = 1'b0;
    blank_lz  = 1'b0;

    do_load(16'hABCD);
    waited = 0;
    while (an4 !== 4'b1011 && waited < 64) begin
      step();
      waited++;
    end
    total++;
    if (an4 !== 4'b1011) begin
      bad++;
      $display("FAIL wait_digit2: got %b expected 1011", an4);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
